int_datapath_md: RTL and testbench
==================================

Name: int_datapath_md

Overview:
- Parametrised successor to the integer datapath.
- Contains a register file with configurable width and depth, pipelined RS/RT operand registers, a registered ALU with a flag register, and a Y-mux write-back path.
- Adds an iterative multiply/divide unit with a start/busy/done handshake that writes HI/LO.
- Sits between the control unit FSM and memory/I/O in the multicycle CPU.

Parameters:
- W, 32, data width in bits (≥4, even).
- NREG, 32, number of registers (power of 2, ≥4). Derived widths: AW=clog2(NREG), SW=clog2(W).

Ports:
- clk  in  1  clock
- reset  in  1  async reset, active-high
- d_en  in  1  register file write enable
- d_addr, s_addr, t_addr  in  AW each  destination/source register addresses
- t_sel  in  2  RT source: 0=regfile T, 1=dt, 2=pc_in, 3={W-4 zeros, C,V,N,Z}
- fs  in  4  ALU function select
- shamt  in  SW  shift amount
- flag_ld  in  1  flag register loads dy[3:0] instead of ALU flags
- md_start  in  1  start multiply/divide
- md_op  in  1  0=unsigned multiply, 1=unsigned divide
- hilo_ld  in  1  HI<=RS, LO<=RT
- y_sel  in  3  write-back/ALU_OUT mux select
- dy, dt, pc_in  in  W each  memory data, immediate/IO data, PC
- rs, d_out  out  W each  RS and RT registers
- alu_out  out  W  Y-mux output (also the register file write data)
- c, v, n, z  out  1 each  flag register
- md_busy, md_done, div_zero  out  1 each  multiply/divide status

Behaviour:
- Reset (async): every register file entry, RS, RT, ALU_R, D_in, HI, LO and flags = 0. FSM = IDLE. md_busy, md_done and div_zero = 0.
- Register file:
  - Write at posedge when d_en=1 and d_addr!=0; write data = alu_out.
  - Reg 0 always reads 0.
  - Reads are combinational; a same-cycle write is not forwarded (reads return the old value).
- RS/RT capture every posedge: RS<=S[s_addr], RT<=t_sel mux.
- ALU is combinational on RS/RT. ALU_R and the flags register every cycle.
- fs codes:
  - 0 S; 1 T; 2 S+T; 3 S-T; 4 AND; 5 OR; 6 XOR; 7 NOR
  - 8 signed SLT; 9 unsigned SLT; A T<<shamt; B T>>shamt (logical); C T>>>shamt (arithmetic)
  - D S+1; E S-1; F 0
- Flags:
  - N = result MSB; Z = (result==0).
  - C = carry-out for add/inc; C = NOT borrow for sub/dec (S≥T unsigned → 1).
  - V = two's-complement overflow for 2, 3, D, E.
  - C and V are 0 for all other fs codes.
  - If flag_ld=1, flags<=dy[3:0] as {C,V,N,Z}.
- D_in captures dy every cycle.
- y_sel: 0 HI, 1 LO, 2 ALU_R, 3 D_in, 4 pc_in, 5 {zeros,C,V,N,Z}, 6/7 ALU_R.
- MD FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on md_start. Operands are latched from RS/RT at that edge and the counter is set to W.
  - Each RUN cycle performs one step: shift-add for multiply, restoring shift-subtract for divide. The counter decrements.
  - On the edge with counter==1: write HI/LO and go to DONE.
  - DONE → IDLE unconditionally.
  - md_busy=1 only in RUN. md_done=1 only in DONE.
  - Latency: start sampled at edge 0 → md_busy high cycles 1..W, md_done high cycle W+1, new HI/LO visible from cycle W+1.
- Results:
  - Multiply: {HI,LO} = RS*RT (2W bits, unsigned).
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (md_op=1, RT=0):
  - IDLE → DONE directly, with LO = all ones and HI = dividend.
  - div_zero=1 during DONE only; md_done at cycle 1.
- Handshake rules:
  - md_start is ignored unless FSM is IDLE.
  - hilo_ld acts only in IDLE and is ignored in RUN/DONE.
  - md_start and hilo_ld together in IDLE: md_start wins.
  - HI/LO are never altered mid-operation.
- Reset mid-operation aborts: FSM = IDLE and HI/LO = 0.
- The register file and ALU remain fully usable while md_busy=1.

Test Plan:
- Reset mid-RUN (W=32), reset after 5 cycles → md_busy=0 immediately, HI=LO=0, a new start completes normally.
- Write 0x7FFFFFFF to r1 and 1 to r2, fs=2 → ALU_R=0x80000000, V=1, N=1, Z=0, C=0. Then fs=3 with r2-r2 → Z=1, C=1.
- Write to r0 with d_en=1, value 0xDEAD → r0 still reads 0. NREG=8: address 7 writes and reads back.
- multu RS=0xFFFFFFFF, RT=2 → md_busy for exactly 32 cycles, md_done cycle 33, HI=0x00000001, LO=0xFFFFFFFE. md_start pulsed mid-run is ignored.
- divu 100/7 → LO=14, HI=2, div_zero=0. divu 5/0 → md_done on cycle 1, div_zero=1, LO=0xFFFFFFFF, HI=5.
- hilo_ld with RS=0xA, RT=0xB in IDLE → HI=0xA, LO=0xB. hilo_ld while busy → no change. W=16 instance: multu 0xFFFF*0xFFFF → HI=0xFFFE, LO=0x0001, done at cycle 17.

Source files
------------

// File: rtl/int_datapath_md.sv
// int_datapath_md
// Integer datapath for the multicycle CPU. It contains a register file, a
// pipelined RS/RT operand stage, a registered ALU with a flag register, and
// a Y-mux write-back path. An iterative multiply/divide unit writes HI/LO.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   d_en, d_addr           register file write enable / destination address
//   s_addr, t_addr         source register addresses (combinational reads)
//   t_sel                  RT source: 0 regfile T, 1 dt, 2 pc_in, 3 flags word
//   fs, shamt              ALU function select, shift amount
//   flag_ld                flag register loads dy[3:0] as {C,V,N,Z}
//   md_start, md_op        start multiply (0) / divide (1), unsigned
//   hilo_ld                HI <= RS, LO <= RT (only while the MD unit is idle)
//   y_sel                  write-back mux: 0 HI, 1 LO, 2 ALU_R, 3 D_in,
//                          4 pc_in, 5 flags word, 6/7 ALU_R
//   dy, dt, pc_in          memory data, immediate/IO data, program counter
//   rs, d_out              RS and RT operand registers
//   alu_out                Y-mux output, which is also the register file write data
//   c, v, n, z             flag register
//   md_busy, md_done       MD unit is iterating / result cycle
//   div_zero               the finished operation was a divide by zero
//   md_state               MD FSM state (debug visibility)
//
// MD handshake: the unit samples md_start only in IDLE and latches its
// operands from RS/RT on that edge. md_busy is high for every iteration
// cycle. md_done is high for exactly one cycle. HI/LO hold the new result
// from that cycle on. The unit ignores md_start and hilo_ld while it is
// busy or done.
module int_datapath_md #(
  parameter int W    = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG),
  localparam int SW  = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_en,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] s_addr,
  input  logic [AW-1:0] t_addr,
  input  logic [1:0]    t_sel,
  input  logic [3:0]    fs,
  input  logic [SW-1:0] shamt,
  input  logic          flag_ld,
  input  logic          md_start,
  input  logic          md_op,
  input  logic          hilo_ld,
  input  logic [2:0]    y_sel,
  input  logic [W-1:0]  dy,
  input  logic [W-1:0]  dt,
  input  logic [W-1:0]  pc_in,
  output logic [W-1:0]  rs,
  output logic [W-1:0]  d_out,
  output logic [W-1:0]  alu_out,
  output logic          c,
  output logic          v,
  output logic          n,
  output logic          z,
  output logic          md_busy,
  output logic          md_done,
  output logic          div_zero,
  output logic [1:0]    md_state
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [SW:0] CNT_INIT = (SW+1)'(W);
  localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [W-1:0] rf [NREG];
  logic [W-1:0] s_val;
  logic [W-1:0] t_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (d_en && (d_addr != '0)) begin
      rf[d_addr] <= alu_out;
    end
  end

  // The read ports do not forward a same-cycle write; they see the old contents.
  assign s_val = (s_addr == '0) ? '0 : rf[s_addr];
  assign t_val = (t_addr == '0) ? '0 : rf[t_addr];

  // ---------------------------------------------------------------------
  // Operand stage, ALU, flags, D_in
  // ---------------------------------------------------------------------
  logic [W-1:0] rs_r, rt_r, alu_r, d_in_r;
  logic         c_r, v_r, n_r, z_r;
  logic [W-1:0] flags_word;
  logic [W-1:0] t_mux;

  assign flags_word = {{(W-4){1'b0}}, c_r, v_r, n_r, z_r};

  always_comb begin
    t_mux = t_val;
    case (t_sel)
      2'd0:    t_mux = t_val;
      2'd1:    t_mux = dt;
      2'd2:    t_mux = pc_in;
      default: t_mux = flags_word;
    endcase
  end

  logic [W-1:0] alu_res;
  logic         alu_c, alu_v;
  logic [W:0]   sum_w;

  // All add-type operations share one (W+1)-bit adder. The top bit is the carry.
  // Subtract adds ~T+1, so the carry is the inverted borrow (S >= T).
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = '0;
    case (fs)
      4'h0: alu_res = rs_r;
      4'h1: alu_res = rt_r;
      4'h2: begin
        sum_w   = {1'b0, rs_r} + {1'b0, rt_r};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (rs_r[W-1] == rt_r[W-1]) && (alu_res[W-1] != rs_r[W-1]);
      end
      4'h3: begin
        sum_w   = {1'b0, rs_r} + {1'b0, ~rt_r} + CNT_ONE[0 +: 1];
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = (rs_r[W-1] != rt_r[W-1]) && (alu_res[W-1] != rs_r[W-1]);
      end
      4'h4: alu_res = rs_r & rt_r;
      4'h5: alu_res = rs_r | rt_r;
      4'h6: alu_res = rs_r ^ rt_r;
      4'h7: alu_res = ~(rs_r | rt_r);
      4'h8: alu_res = {{(W-1){1'b0}}, ($signed(rs_r) < $signed(rt_r))};
      4'h9: alu_res = {{(W-1){1'b0}}, (rs_r < rt_r)};
      4'hA: alu_res = rt_r << shamt;
      4'hB: alu_res = rt_r >> shamt;
      4'hC: alu_res = $signed(rt_r) >>> shamt;
      4'hD: begin
        sum_w   = {1'b0, rs_r} + (W+1)'(1);
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = ~rs_r[W-1] & alu_res[W-1];
      end
      4'hE: begin
        // S + all-ones: the carry is set whenever S != 0, that is, no borrow.
        sum_w   = {1'b0, rs_r} + {1'b0, {W{1'b1}}};
        alu_res = sum_w[W-1:0];
        alu_c   = sum_w[W];
        alu_v   = rs_r[W-1] & ~alu_res[W-1];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_r   <= '0;
      rt_r   <= '0;
      alu_r  <= '0;
      d_in_r <= '0;
      c_r    <= 1'b0;
      v_r    <= 1'b0;
      n_r    <= 1'b0;
      z_r    <= 1'b0;
    end else begin
      rs_r   <= s_val;
      rt_r   <= t_mux;
      alu_r  <= alu_res;
      d_in_r <= dy;
      if (flag_ld) begin
        {c_r, v_r, n_r, z_r} <= dy[3:0];
      end else begin
        c_r <= alu_c;
        v_r <= alu_v;
        n_r <= alu_res[W-1];
        z_r <= (alu_res == '0);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Multiply / divide unit
  // ---------------------------------------------------------------------
  md_state_e    md_st, md_st_nx;
  logic [SW:0]  md_cnt;
  logic         md_op_r;
  logic         dz_r;
  logic [W-1:0] md_m;     // multiplicand (multiply) or divisor (divide)
  logic [W-1:0] acc_hi;   // running product high half / partial remainder
  logic [W-1:0] acc_lo;   // multiplier bits then product low half / dividend then quotient
  logic [W-1:0] hi_r, lo_r;
  logic [W-1:0] step_hi, step_lo;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W-1:0] div_diff;
  logic         start_dz;

  assign start_dz = md_op && (rt_r == '0);

  // One iteration step.
  // Multiply: conditionally add the multiplicand into the high half, then
  // shift the whole {carry, hi, lo} right by one bit.
  // Divide: shift the next dividend bit into the remainder, and subtract
  // the divisor when it fits. The remainder is always below the divisor,
  // so a W-bit difference is enough.
  always_comb begin
    mul_sum   = '0;
    div_shift = '0;
    div_diff  = '0;
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (!md_op_r) begin
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_m} : '0);
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else begin
      div_shift = {acc_hi, acc_lo[W-1]};
      div_diff  = div_shift[W-1:0] - md_m;
      if (div_shift >= {1'b0, md_m}) begin
        step_hi = div_diff;
        step_lo = {acc_lo[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {acc_lo[W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    md_st_nx = md_st;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    div_zero = 1'b0;
    case (md_st)
      MD_IDLE: begin
        if (md_start) md_st_nx = start_dz ? MD_DONE : MD_RUN;
      end
      MD_RUN: begin
        md_busy = 1'b1;
        if (md_cnt == CNT_ONE) md_st_nx = MD_DONE;
      end
      MD_DONE: begin
        md_done  = 1'b1;
        div_zero = dz_r;
        md_st_nx = MD_IDLE;
      end
      default: md_st_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_st   <= MD_IDLE;
      md_cnt  <= '0;
      md_op_r <= 1'b0;
      dz_r    <= 1'b0;
      md_m    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      md_st <= md_st_nx;
      case (md_st)
        MD_IDLE: begin
          // md_start takes priority over hilo_ld.
          if (md_start) begin
            md_op_r <= md_op;
            md_cnt  <= CNT_INIT;
            dz_r    <= start_dz;
            acc_hi  <= '0;
            if (start_dz) begin
              hi_r <= rs_r;
              lo_r <= '1;
            end else if (md_op) begin
              md_m   <= rt_r;
              acc_lo <= rs_r;
            end else begin
              md_m   <= rs_r;
              acc_lo <= rt_r;
            end
          end else if (hilo_ld) begin
            hi_r <= rs_r;
            lo_r <= rt_r;
          end
        end
        MD_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          md_cnt <= md_cnt - CNT_ONE;
          // The last step writes straight through to HI/LO.
          if (md_cnt == CNT_ONE) begin
            hi_r <= step_hi;
            lo_r <= step_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign md_state = md_st;

  // ---------------------------------------------------------------------
  // Outputs / Y-mux
  // ---------------------------------------------------------------------
  assign rs    = rs_r;
  assign d_out = rt_r;
  assign c     = c_r;
  assign v     = v_r;
  assign n     = n_r;
  assign z     = z_r;

  always_comb begin
    alu_out = alu_r;
    case (y_sel)
      3'd0:    alu_out = hi_r;
      3'd1:    alu_out = lo_r;
      3'd2:    alu_out = alu_r;
      3'd3:    alu_out = d_in_r;
      3'd4:    alu_out = pc_in;
      3'd5:    alu_out = flags_word;
      default: alu_out = alu_r;
    endcase
  end

endmodule

// File: tb/tb_int_datapath_md.sv
// Testbench for int_datapath_md. It runs a W=32/NREG=32 instance plus a
// W=16/NREG=8 instance. An arithmetic reference model checks the ALU,
// register file, pipeline and MD results.
module tb_int_datapath_md;
  localparam int W = 32, NREG = 32, AW = 5, SW = 5;
  localparam int W2 = 16, NREG2 = 8, AW2 = 3, SW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic d_en, flag_ld, md_start, md_op, hilo_ld;
  logic [AW-1:0] d_addr, s_addr, t_addr;
  logic [1:0] t_sel;
  logic [3:0] fs;
  logic [SW-1:0] shamt;
  logic [2:0] y_sel;
  logic [W-1:0] dy, dt, pc_in, rs, d_out, alu_out;
  logic c, v, n, z, md_busy, md_done, div_zero;
  logic [1:0] md_state;

  logic b_d_en, b_md_start, b_hilo_ld;
  logic [AW2-1:0] b_d_addr, b_s_addr, b_t_addr;
  logic [2:0] b_y_sel;
  logic [W2-1:0] b_pc_in, b_rs, b_d_out, b_alu_out;
  logic b_c, b_v, b_n, b_z, b_md_busy, b_md_done, b_div_zero;
  logic [1:0] b_md_state;

  int_datapath_md #(.W(W), .NREG(NREG)) dut (
    .clk(clk), .reset(reset), .d_en(d_en), .d_addr(d_addr), .s_addr(s_addr), .t_addr(t_addr),
    .t_sel(t_sel), .fs(fs), .shamt(shamt), .flag_ld(flag_ld), .md_start(md_start), .md_op(md_op),
    .hilo_ld(hilo_ld), .y_sel(y_sel), .dy(dy), .dt(dt), .pc_in(pc_in), .rs(rs), .d_out(d_out),
    .alu_out(alu_out), .c(c), .v(v), .n(n), .z(z), .md_busy(md_busy), .md_done(md_done),
    .div_zero(div_zero), .md_state(md_state));

  int_datapath_md #(.W(W2), .NREG(NREG2)) dut16 (
    .clk(clk), .reset(reset), .d_en(b_d_en), .d_addr(b_d_addr), .s_addr(b_s_addr), .t_addr(b_t_addr),
    .t_sel(2'd0), .fs(4'h0), .shamt({SW2{1'b0}}), .flag_ld(1'b0), .md_start(b_md_start), .md_op(1'b0),
    .hilo_ld(b_hilo_ld), .y_sel(b_y_sel), .dy({W2{1'b0}}), .dt({W2{1'b0}}), .pc_in(b_pc_in), .rs(b_rs),
    .d_out(b_d_out), .alu_out(b_alu_out), .c(b_c), .v(b_v), .n(b_n), .z(b_z), .md_busy(b_md_busy),
    .md_done(b_md_done), .div_zero(b_div_zero), .md_state(b_md_state));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] regs_m [NREG];
  logic [W-1:0] rs_m, rt_m, alu_r_m, d_in_m, hi_m, lo_m;
  logic [3:0] flg_m; // {C,V,N,Z}

  function automatic logic [W+3:0] ref_alu(input logic [3:0] f, input logic [W-1:0] s, input logic [W-1:0] t,
                                           input logic [SW-1:0] sh);
    longint us, ut, ss, st, two_w, smax, smin;
    logic signed [W-1:0] ts;
    logic [W-1:0] r;
    logic cf, vf;
    us = s; ut = t; ss = $signed(s); st = $signed(t);
    two_w = longint'(1) << W; smax = two_w / 2 - 1; smin = -(two_w / 2);
    cf = 1'b0; vf = 1'b0; r = '0; ts = t;
    case (f)
      4'h0: r = s;
      4'h1: r = t;
      4'h2: begin r = s + t; cf = (us + ut) >= two_w; vf = (ss + st > smax) || (ss + st < smin); end
      4'h3: begin r = s - t; cf = us >= ut; vf = (ss - st > smax) || (ss - st < smin); end
      4'h4: r = s & t;
      4'h5: r = s | t;
      4'h6: r = s ^ t;
      4'h7: r = ~(s | t);
      4'h8: r = (ss < st) ? 1 : 0;
      4'h9: r = (us < ut) ? 1 : 0;
      4'hA: r = t << sh;
      4'hB: r = t >> sh;
      4'hC: r = ts >>> sh;
      4'hD: begin r = s + 1; cf = (us + 1) >= two_w; vf = (ss + 1) > smax; end
      4'hE: begin r = s - 1; cf = us >= 1; vf = (ss - 1) < smin; end
      default: r = '0;
    endcase
    return {cf, vf, r[W-1], (r == '0), r};
  endfunction

  function automatic logic [W-1:0] ymux_m(input logic [2:0] sel);
    case (sel)
      3'd0: return hi_m;
      3'd1: return lo_m;
      3'd3: return d_in_m;
      3'd4: return pc_in;
      3'd5: return {{(W-4){1'b0}}, flg_m};
      default: return alu_r_m;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) regs_m[i] = '0;
    rs_m = '0; rt_m = '0; alu_r_m = '0; d_in_m = '0; hi_m = '0; lo_m = '0; flg_m = '0;
  endtask

  // One clock: advance the DUTs and the model of everything except HI/LO.
  task automatic tick();
    logic [W-1:0] wdata, s_nx, t_nx;
    logic [W+3:0] a;
    wdata = ymux_m(y_sel);
    s_nx = regs_m[s_addr];
    case (t_sel)
      2'd0: t_nx = regs_m[t_addr];
      2'd1: t_nx = dt;
      2'd2: t_nx = pc_in;
      default: t_nx = {{(W-4){1'b0}}, flg_m};
    endcase
    a = ref_alu(fs, rs_m, rt_m, shamt);
    @(posedge clk); #1;
    if (d_en && d_addr != '0) regs_m[d_addr] = wdata;
    rs_m = s_nx; rt_m = t_nx; alu_r_m = a[W-1:0];
    flg_m = flag_ld ? dy[3:0] : a[W+3:W];
    d_in_m = dy;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [W-1:0] val);
    d_en = 1'b1; d_addr = a; y_sel = 3'd4; pc_in = val;
    tick();
    d_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    checks++; if (rs !== '0) begin errors++; $display("FAIL reset rs: got %h expected 0", rs); end
    checks++; if (d_out !== '0) begin errors++; $display("FAIL reset d_out: got %h expected 0", d_out); end
    checks++; if ({c, v, n, z} !== 4'b0) begin errors++; $display("FAIL reset flags: got %b expected 0000", {c, v, n, z}); end
    checks++; if ({md_busy, md_done, div_zero} !== 3'b0) begin errors++; $display("FAIL reset md status: got %b expected 000", {md_busy, md_done, div_zero}); end
    for (int sel = 0; sel < 6; sel++) begin
      y_sel = 3'(sel); #1;
      checks++; if (alu_out !== '0) begin errors++; $display("FAIL reset y_sel%0d: got %h expected 0", sel, alu_out); end
    end
    reset = 1'b0;
    for (int i = 1; i < 4; i++) begin
      s_addr = AW'(i * 9); t_addr = AW'(i * 5); tick();
      checks++; if (rs !== '0 || d_out !== '0) begin errors++; $display("FAIL reset regfile r%0d: got %h/%h expected 0", i, rs, d_out); end
    end
  endtask

  task automatic test_regfile();
    write_reg(5'd0, 32'hDEAD);
    s_addr = 5'd0; t_addr = 5'd0; t_sel = 2'd0; tick();
    checks++; if (rs !== '0) begin errors++; $display("FAIL r0_write: got %h expected 0", rs); end
    write_reg(5'd3, 32'h1234);
    s_addr = 5'd3;
    write_reg(5'd3, 32'h5678);
    checks++; if (rs !== 32'h1234) begin errors++; $display("FAIL no_forward: got %h expected 00001234", rs); end
    tick();
    checks++; if (rs !== 32'h5678) begin errors++; $display("FAIL write_back: got %h expected 00005678", rs); end
    write_reg(5'd31, 32'hCAFE_F00D);
    s_addr = 5'd31; tick();
    checks++; if (rs !== 32'hCAFE_F00D) begin errors++; $display("FAIL r31: got %h expected cafef00d", rs); end
    for (int i = 0; i < 16; i++) write_reg(AW'($urandom_range(0, NREG - 1)), $urandom);
    for (int i = 0; i < 16; i++) begin
      s_addr = AW'($urandom_range(0, NREG - 1)); t_addr = AW'($urandom_range(0, NREG - 1)); tick();
      checks++; if (rs !== rs_m || d_out !== rt_m) begin errors++; $display("FAIL regfile_read: got %h/%h expected %h/%h", rs, d_out, rs_m, rt_m); end
    end
  endtask

  task automatic test_alu_directed();
    write_reg(5'd1, 32'h7FFF_FFFF);
    write_reg(5'd2, 32'h1);
    s_addr = 5'd1; t_addr = 5'd2; t_sel = 2'd0; fs = 4'h2; y_sel = 3'd2;
    tick(); tick();
    checks++; if (alu_out !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf result: got %h expected 80000000", alu_out); end
    checks++; if ({c, v, n, z} !== 4'b0110) begin errors++; $display("FAIL add_ovf flags: got %b expected 0110", {c, v, n, z}); end
    s_addr = 5'd2; fs = 4'h3;
    tick(); tick();
    checks++; if (alu_out !== '0) begin errors++; $display("FAIL sub_zero result: got %h expected 0", alu_out); end
    checks++; if ({c, v, n, z} !== 4'b1001) begin errors++; $display("FAIL sub_zero flags: got %b expected 1001", {c, v, n, z}); end
    t_sel = 2'd3; y_sel = 3'd5; tick();
    checks++; if (d_out !== 32'h9) begin errors++; $display("FAIL t_sel_flags: got %h expected 9", d_out); end
    checks++; if (alu_out !== 32'h9) begin errors++; $display("FAIL y_sel_flags: got %h expected 9", alu_out); end
    flag_ld = 1'b1; dy = 32'hABCD_0006; tick(); flag_ld = 1'b0;
    checks++; if ({c, v, n, z} !== 4'b0110) begin errors++; $display("FAIL flag_ld: got %b expected 0110", {c, v, n, z}); end
    y_sel = 3'd3; #1;
    checks++; if (alu_out !== 32'hABCD_0006) begin errors++; $display("FAIL d_in: got %h expected abcd0006", alu_out); end
    t_sel = 2'd0;
  endtask

  task automatic test_alu_random();
    logic [W-1:0] corners [6];
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    for (int i = 0; i < 8; i++) write_reg(AW'(i + 8), corners[$urandom_range(0, 5)]);
    for (int i = 0; i < 80; i++) begin
      s_addr = AW'($urandom_range(0, NREG - 1)); t_addr = AW'($urandom_range(0, NREG - 1));
      t_sel = 2'($urandom_range(0, 3)); fs = 4'($urandom_range(0, 15)); shamt = SW'($urandom);
      dt = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      pc_in = $urandom; dy = $urandom; flag_ld = ($urandom_range(0, 7) == 0);
      y_sel = 3'($urandom_range(0, 7)); d_en = ($urandom_range(0, 3) == 0); d_addr = AW'($urandom_range(0, NREG - 1));
      tick();
      checks++; if (rs !== rs_m || d_out !== rt_m) begin errors++; $display("FAIL alu_rand operands %0d: got %h/%h expected %h/%h", i, rs, d_out, rs_m, rt_m); end
      checks++; if (alu_out !== ymux_m(y_sel)) begin errors++; $display("FAIL alu_rand y %0d: got %h expected %h", i, alu_out, ymux_m(y_sel)); end
      checks++; if ({c, v, n, z} !== flg_m) begin errors++; $display("FAIL alu_rand flags %0d: got %b expected %b", i, {c, v, n, z}, flg_m); end
    end
    d_en = 1'b0; flag_ld = 1'b0; t_sel = 2'd0; y_sel = 3'd2;
  endtask

  task automatic test_hilo();
    write_reg(5'd5, 32'hA);
    write_reg(5'd6, 32'hB);
    s_addr = 5'd5; t_addr = 5'd6; tick();
    hilo_ld = 1'b1; hi_m = rs_m; lo_m = rt_m; tick(); hilo_ld = 1'b0;
    y_sel = 3'd0; #1;
    checks++; if (alu_out !== 32'hA) begin errors++; $display("FAIL hilo_ld HI: got %h expected a", alu_out); end
    y_sel = 3'd1; #1;
    checks++; if (alu_out !== 32'hB) begin errors++; $display("FAIL hilo_ld LO: got %h expected b", alu_out); end
    y_sel = 3'd2;
  endtask

  task automatic test_multu();
    write_reg(5'd5, 32'hFFFF_FFFF);
    write_reg(5'd6, 32'h2);
    s_addr = 5'd5; t_addr = 5'd6; y_sel = 3'd2; tick();
    md_op = 1'b0; md_start = 1'b1; tick(); md_start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      checks++; if (md_busy !== (k <= W) || md_done !== (k == W + 1)) begin errors++; $display("FAIL multu timing cycle %0d: got busy=%b done=%b", k, md_busy, md_done); end
      if (k == 20) begin
        y_sel = 3'd0; #1;
        checks++; if (alu_out !== hi_m) begin errors++; $display("FAIL multu HI mid-run: got %h expected %h", alu_out, hi_m); end
        y_sel = 3'd1; #1;
        checks++; if (alu_out !== lo_m) begin errors++; $display("FAIL multu LO mid-run: got %h expected %h", alu_out, lo_m); end
        y_sel = 3'd2;
      end
      if (k == W + 1) begin
        hi_m = 32'h1; lo_m = 32'hFFFF_FFFE;
        y_sel = 3'd0; #1;
        checks++; if (alu_out !== 32'h1) begin errors++; $display("FAIL multu HI: got %h expected 00000001", alu_out); end
        y_sel = 3'd1; #1;
        checks++; if (alu_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu LO: got %h expected fffffffe", alu_out); end
        y_sel = 3'd2;
      end
      md_start = (k == 10); hilo_ld = (k == 12);
      tick();
      md_start = 1'b0; hilo_ld = 1'b0;
    end
    checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL multu idle: got busy=%b done=%b", md_busy, md_done); end
  endtask

  task automatic test_md_ops();
    logic [W:0] tab [6];
    logic [W-1:0] ta [6];
    logic op, dz;
    logic [W-1:0] a, b, exp_hi, exp_lo;
    logic [2*W-1:0] prod;
    int lat;
    tab = '{{1'b1, 32'd7}, {1'b1, 32'd0}, {1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h1}, {1'b1, 32'd10}, {1'b0, 32'h0}};
    ta  = '{32'd100, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h1234_5678};
    for (int e = 0; e < 14; e++) begin
      if (e < 6) begin op = tab[e][W]; b = tab[e][W-1:0]; a = ta[e]; end
      else begin op = 1'($urandom); a = $urandom; b = (e[0]) ? $urandom : W'($urandom_range(1, 300)); end
      dz = op && (b == '0);
      if (op == 1'b0) begin prod = {{W{1'b0}}, a} * {{W{1'b0}}, b}; exp_hi = prod[2*W-1:W]; exp_lo = prod[W-1:0]; end
      else if (dz) begin exp_hi = a; exp_lo = '1; end
      else begin exp_hi = a % b; exp_lo = a / b; end
      lat = dz ? 1 : W + 1;
      write_reg(5'd7, a);
      write_reg(5'd8, b);
      s_addr = 5'd7; t_addr = 5'd8; t_sel = 2'd0; y_sel = 3'd2; tick();
      md_op = op; md_start = 1'b1; tick(); md_start = 1'b0;
      for (int k = 1; k <= lat; k++) begin
        checks++; if (md_busy !== (k < lat) || md_done !== (k == lat)) begin errors++; $display("FAIL md_op %0d timing cycle %0d: got busy=%b done=%b", e, k, md_busy, md_done); end
        checks++; if (alu_out !== alu_r_m) begin errors++; $display("FAIL md_op %0d alu while busy: got %h expected %h", e, alu_out, alu_r_m); end
        if (k < lat) begin
          fs = 4'($urandom_range(0, 15)); d_en = ($urandom_range(0, 1) == 1); d_addr = AW'($urandom_range(1, 12));
          tick();
          d_en = 1'b0;
        end
      end
      checks++; if (div_zero !== dz) begin errors++; $display("FAIL md_op %0d div_zero: got %b expected %b", e, div_zero, dz); end
      y_sel = 3'd0; #1;
      checks++; if (alu_out !== exp_hi) begin errors++; $display("FAIL md_op %0d HI: got %h expected %h", e, alu_out, exp_hi); end
      y_sel = 3'd1; #1;
      checks++; if (alu_out !== exp_lo) begin errors++; $display("FAIL md_op %0d LO: got %h expected %h", e, alu_out, exp_lo); end
      hi_m = exp_hi; lo_m = exp_lo; y_sel = 3'd2;
      tick();
      checks++; if (md_done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL md_op %0d done clear: got done=%b dz=%b", e, md_done, div_zero); end
    end
  endtask

  task automatic test_reset_mid_run();
    write_reg(5'd5, 32'hFFFF_FFFF);
    write_reg(5'd6, 32'h3);
    s_addr = 5'd5; t_addr = 5'd6; tick();
    md_op = 1'b0; md_start = 1'b1; tick(); md_start = 1'b0;
    repeat (5) tick();
    reset = 1'b1; #1;
    model_clear();
    checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL reset_mid busy: got busy=%b done=%b", md_busy, md_done); end
    y_sel = 3'd0; #1;
    checks++; if (alu_out !== '0) begin errors++; $display("FAIL reset_mid HI: got %h expected 0", alu_out); end
    y_sel = 3'd1; #1;
    checks++; if (alu_out !== '0) begin errors++; $display("FAIL reset_mid LO: got %h expected 0", alu_out); end
    y_sel = 3'd2; reset = 1'b0;
    tick();
    checks++; if (rs !== '0) begin errors++; $display("FAIL reset_mid regfile: got %h expected 0", rs); end
    write_reg(5'd5, 32'd123);
    write_reg(5'd6, 32'd456);
    tick();
    md_start = 1'b1; tick(); md_start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      checks++; if (md_busy !== (k <= W) || md_done !== (k == W + 1)) begin errors++; $display("FAIL reset_mid restart cycle %0d: got busy=%b done=%b", k, md_busy, md_done); end
      if (k <= W) tick();
    end
    y_sel = 3'd1; #1;
    checks++; if (alu_out !== 32'd56088) begin errors++; $display("FAIL reset_mid restart LO: got %h expected %h", alu_out, 32'd56088); end
    hi_m = '0; lo_m = 32'd56088; y_sel = 3'd2;
    tick();
  endtask

  task automatic test_w16();
    b_d_en = 1'b1; b_y_sel = 3'd4; b_pc_in = 16'hFFFF; b_d_addr = 3'd7; tick();
    b_d_addr = 3'd6; tick();
    b_d_addr = 3'd0; b_pc_in = 16'hDEAD; tick();
    b_d_en = 1'b0; b_s_addr = 3'd7; b_t_addr = 3'd0; tick();
    checks++; if (b_rs !== 16'hFFFF || b_d_out !== 16'h0) begin errors++; $display("FAIL w16 r7/r0: got %h/%h expected ffff/0000", b_rs, b_d_out); end
    b_t_addr = 3'd6; tick();
    b_md_start = 1'b1; tick(); b_md_start = 1'b0;
    for (int k = 1; k <= W2 + 1; k++) begin
      checks++; if (b_md_busy !== (k <= W2) || b_md_done !== (k == W2 + 1)) begin errors++; $display("FAIL w16 timing cycle %0d: got busy=%b done=%b", k, b_md_busy, b_md_done); end
      if (k <= W2) tick();
    end
    b_y_sel = 3'd0; #1;
    checks++; if (b_alu_out !== 16'hFFFE) begin errors++; $display("FAIL w16 HI: got %h expected fffe", b_alu_out); end
    b_y_sel = 3'd1; #1;
    checks++; if (b_alu_out !== 16'h0001) begin errors++; $display("FAIL w16 LO: got %h expected 0001", b_alu_out); end
    tick();
  endtask

  initial begin
    reset = 1'b1; d_en = 1'b0; d_addr = '0; s_addr = '0; t_addr = '0; t_sel = '0; fs = '0; shamt = '0;
    flag_ld = 1'b0; md_start = 1'b0; md_op = 1'b0; hilo_ld = 1'b0; y_sel = 3'd2; dy = '0; dt = '0; pc_in = '0;
    b_d_en = 1'b0; b_md_start = 1'b0; b_hilo_ld = 1'b0; b_d_addr = '0; b_s_addr = '0; b_t_addr = '0;
    b_y_sel = 3'd2; b_pc_in = '0;
    test_reset();
    test_regfile();
    test_alu_directed();
    test_alu_random();
    test_hilo();
    test_multu();
    test_md_ops();
    test_reset_mid_run();
    test_w16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
